// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame-buffer write arbiter.
// Holds the FSM state encoding, the bus width defaults and the mode constants.
package fb_arb_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 12;

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_PROC = 1'b1;

    typedef enum logic [1:0] {
        ST_PASS      = 2'd0,
        ST_DRAIN_P2P = 2'd1,
        ST_PROC      = 2'd2,
        ST_DRAIN_P2A = 2'd3
    } arb_state_t;

    // A count of 0..depth needs one more bit than a pointer does.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Camera, ALU and memory write-port signals of the frame-buffer arbiter.
// The arbiter uses the arb modport; sources and sinks use the src modport.
interface fb_write_arbiter_if
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cam_valid;
    logic              cam_ready;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport arb (
        input  cam_valid, cam_addr, cam_data, alu_valid, alu_addr, alu_data,
        output cam_ready, alu_ready, mem_wen, mem_addr, mem_wdata
    );

    modport src (
        output cam_valid, cam_addr, cam_data, alu_valid, alu_addr, alu_data,
        input  cam_ready, alu_ready, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_wr_fifo.sv
// Small register-based synchronous FIFO for camera writes.
// The caller never pushes when full or pops when empty; count_o reports occupancy.
module fb_wr_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ADDR_W_DEF + DATA_W_DEF,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge sys_clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame-buffer write port between the camera FIFO and the ALU,
// switching passthrough/process mode only at a frame boundary once the FIFO drains.
//
//  state        | meaning
//  ST_PASS      | passthrough: camera FIFO drains to memory, ALU held off
//  ST_DRAIN_P2P | heading to PROC: flush camera FIFO, ALU held off
//  ST_PROC      | process: ALU writes, camera pre-empts at watermark or when ALU idle
//  ST_DRAIN_P2A | heading to PASS: flush camera FIFO, ALU held off
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int HIGH_WM    = 3
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                mode_req,
    input  logic                frame_start,
    fb_write_arbiter_if.arb     bus,
    output logic                mode_active,
    output logic                switching,
    output logic                overflow_err
);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WM_C    = CNT_W'(HIGH_WM);

    arb_state_t               state_q, state_d;
    logic                     cam_ready_q;
    logic                     mem_wen_q;
    logic [ADDR_W-1:0]        mem_addr_q;
    logic [DATA_W-1:0]        mem_wdata_q;
    logic                     mode_active_q;
    logic                     switching_q;
    logic                     overflow_q;

    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [ADDR_W+DATA_W-1:0] fifo_rdata;
    logic                     push, pop, drop;
    logic                     alu_rdy, alu_grant;

    assign push = bus.cam_valid & cam_ready_q;
    // A camera that ignores backpressure while the FIFO is full loses that pixel.
    assign drop = bus.cam_valid & ~cam_ready_q & (count == DEPTH_C);

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W + DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.cam_addr, bus.cam_data}),
        .rdata_o (fifo_rdata),
        .count_o (count)
    );

    always_comb begin
        pop     = 1'b0;
        alu_rdy = 1'b0;
        if (state_q == ST_PROC) begin
            alu_rdy = (count < WM_C);
            pop     = (count >= WM_C) || ((count != '0) && !bus.alu_valid);
        end else begin
            pop     = (count != '0);
        end
    end

    assign alu_grant = alu_rdy & bus.alu_valid;
    assign cnt_nxt   = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PASS:      if (mode_req == MODE_PROC && frame_start) state_d = ST_DRAIN_P2P;
            ST_DRAIN_P2P: if (cnt_nxt == '0) state_d = ST_PROC;
            ST_PROC:      if (mode_req == MODE_PASS && frame_start) state_d = ST_DRAIN_P2A;
            ST_DRAIN_P2A: if (cnt_nxt == '0) state_d = ST_PASS;
            default:      state_d = ST_PASS;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PASS;
            cam_ready_q   <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mode_active_q <= 1'b0;
            switching_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cam_ready_q   <= (cnt_nxt < DEPTH_C);
            mem_wen_q     <= pop | alu_grant;
            if (pop) begin
                mem_addr_q  <= fifo_rdata[ADDR_W+DATA_W-1:DATA_W];
                mem_wdata_q <= fifo_rdata[DATA_W-1:0];
            end else if (alu_grant) begin
                mem_addr_q  <= bus.alu_addr;
                mem_wdata_q <= bus.alu_data;
            end
            mode_active_q <= (state_d == ST_PROC) || (state_d == ST_DRAIN_P2A);
            switching_q   <= (state_d == ST_DRAIN_P2P) || (state_d == ST_DRAIN_P2A);
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign bus.cam_ready = cam_ready_q;
    assign bus.alu_ready = alu_rdy;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign mode_active   = mode_active_q;
    assign switching     = switching_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a default build plus a HIGH_WM=5 build
// in which the ALU can hold the camera off long enough to overflow the FIFO.
module tb_fb_write_arbiter;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic rst_n, mode_req, frame_start, mode_active, switching, overflow_err;
    logic rst2_n, mode_req2, frame_start2, ma2, sw2, ovf2;

    fb_write_arbiter_if #(.ADDR_W(19), .DATA_W(12)) bus1 ();
    fb_write_arbiter_if #(.ADDR_W(19), .DATA_W(12)) bus2 ();

    fb_write_arbiter #(.ADDR_W(19), .DATA_W(12), .FIFO_DEPTH(4), .HIGH_WM(3)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .mode_req     (mode_req),
        .frame_start  (frame_start),
        .bus          (bus1),
        .mode_active  (mode_active),
        .switching    (switching),
        .overflow_err (overflow_err)
    );

    fb_write_arbiter #(.ADDR_W(19), .DATA_W(12), .FIFO_DEPTH(4), .HIGH_WM(5)) dut_nowm (
        .sys_clk      (sys_clk),
        .rst_n        (rst2_n),
        .mode_req     (mode_req2),
        .frame_start  (frame_start2),
        .bus          (bus2),
        .mode_active  (ma2),
        .switching    (sw2),
        .overflow_err (ovf2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic expc;
        int   idx;

        rst_n = 1'b0; mode_req = 1'b0; frame_start = 1'b0;
        bus1.cam_valid = 1'b0; bus1.cam_addr = '0; bus1.cam_data = '0;
        bus1.alu_valid = 1'b0; bus1.alu_addr = '0; bus1.alu_data = '0;
        rst2_n = 1'b0; mode_req2 = 1'b0; frame_start2 = 1'b0;
        bus2.cam_valid = 1'b0; bus2.cam_addr = '0; bus2.cam_data = '0;
        bus2.alu_valid = 1'b0; bus2.alu_addr = '0; bus2.alu_data = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_mem_wen",   bus1.mem_wen,   0);
        chk("rst_mem_addr",  bus1.mem_addr,  0);
        chk("rst_mem_wdata", bus1.mem_wdata, 0);
        chk("rst_cam_ready", bus1.cam_ready, 0);
        chk("rst_alu_ready", bus1.alu_ready, 0);
        chk("rst_mode",      mode_active,    0);
        chk("rst_switching", switching,      0);
        chk("rst_overflow",  overflow_err,   0);
        rst_n = 1'b1; rst2_n = 1'b1;
        chk("ready_at_release", bus1.cam_ready, 0);
        tick();
        chk("ready_rise", bus1.cam_ready, 1);

        // 1: PASS streaming, one cycle of latency through FIFO and output register
        bus1.cam_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus1.cam_addr = 19'(i);
            bus1.cam_data = 12'hA00 + 12'(i);
            tick();
            if (i == 0) begin
                chk("t1_first_idle", bus1.mem_wen, 0);
            end else begin
                chk("t1_wen",   bus1.mem_wen,   1);
                chk("t1_addr",  bus1.mem_addr,  i - 1);
                chk("t1_wdata", bus1.mem_wdata, 32'hA00 + i - 1);
            end
        end
        bus1.cam_valid = 1'b0;
        tick();
        chk("t1_last_addr",  bus1.mem_addr,  9);
        chk("t1_last_wdata", bus1.mem_wdata, 32'hA09);
        tick();
        chk("t1_idle_wen",  bus1.mem_wen,  0);
        chk("t1_addr_hold", bus1.mem_addr, 9);
        chk("t1_no_ovf",    overflow_err,  0);

        // 2: ALU locked out in PASS
        bus1.alu_valid = 1'b1; bus1.alu_addr = 19'h100; bus1.alu_data = 12'h123;
        for (int i = 0; i < 20; i++) begin
            chk("t2_alu_ready", bus1.alu_ready, 0);
            tick();
            chk("t2_no_write", bus1.mem_wen, 0);
        end
        bus1.alu_valid = 1'b0;

        // 3: switch to PROC with three camera writes in flight
        mode_req = 1'b1;
        tick();
        chk("t3_req_alone_sw", switching,   0);
        chk("t3_req_alone_ma", mode_active, 0);
        bus1.cam_valid = 1'b1; bus1.cam_addr = 19'h20; bus1.cam_data = 12'hC20;
        frame_start = 1'b1;
        tick();
        chk("t3_sw0", switching,    1);
        chk("t3_ma0", mode_active,  0);
        chk("t3_wen0", bus1.mem_wen, 0);
        frame_start = 1'b0;
        bus1.cam_addr = 19'h21; bus1.cam_data = 12'hC21;
        tick();
        chk("t3_sw1",   switching,     1);
        chk("t3_addr1", bus1.mem_addr, 32'h20);
        bus1.cam_addr = 19'h22; bus1.cam_data = 12'hC22;
        tick();
        chk("t3_sw2",   switching,     1);
        chk("t3_addr2", bus1.mem_addr, 32'h21);
        bus1.cam_valid = 1'b0;
        tick();
        chk("t3_sw_end",  switching,      0);
        chk("t3_ma_end",  mode_active,    1);
        chk("t3_wen3",    bus1.mem_wen,   1);
        chk("t3_addr3",   bus1.mem_addr,  32'h22);
        chk("t3_data3",   bus1.mem_wdata, 32'hC22);
        chk("t3_alu_rdy", bus1.alu_ready, 1);

        // 4: PROC, ALU steady, camera every other cycle; camera pre-empts at count 3
        bus1.alu_valid = 1'b1; bus1.alu_addr = 19'h100; bus1.alu_data = 12'h5A5;
        for (int k = 0; k < 12; k++) begin
            bus1.cam_valid = (k % 2 == 0);
            bus1.cam_addr  = 19'h40 + 19'(k / 2);
            bus1.cam_data  = 12'hB00 + 12'(k / 2);
            expc = (k >= 5) && (k % 2 == 1);
            idx  = (k - 5) / 2;
            chk("t4_alu_ready", bus1.alu_ready, !expc);
            tick();
            chk("t4_wen", bus1.mem_wen, 1);
            if (expc) begin
                chk("t4_cam_addr", bus1.mem_addr,  32'h40 + idx);
                chk("t4_cam_data", bus1.mem_wdata, 32'hB00 + idx);
            end else begin
                chk("t4_alu_addr", bus1.mem_addr,  32'h100);
                chk("t4_alu_data", bus1.mem_wdata, 32'h5A5);
            end
        end
        bus1.alu_valid = 1'b0; bus1.cam_valid = 1'b0;
        tick();
        chk("t4_tail4_addr", bus1.mem_addr,  32'h44);
        chk("t4_tail4_data", bus1.mem_wdata, 32'hB04);
        tick();
        chk("t4_tail5_addr", bus1.mem_addr,  32'h45);
        chk("t4_tail5_data", bus1.mem_wdata, 32'hB05);
        tick();
        chk("t4_idle_wen", bus1.mem_wen, 0);
        chk("t4_no_ovf",   overflow_err, 0);

        // Back to PASS; a frame_start during the drain is ignored
        mode_req = 1'b0; frame_start = 1'b1;
        tick();
        chk("p2a_sw", switching,   1);
        chk("p2a_ma", mode_active, 1);
        mode_req = 1'b1;
        tick();
        chk("p2a_done_sw", switching,   0);
        chk("p2a_done_ma", mode_active, 0);
        frame_start = 1'b0;
        tick();
        chk("p2a_no_pending_sw", switching,      0);
        chk("p2a_pass_alu_rdy",  bus1.alu_ready, 0);

        // 6: reset in the middle of DRAIN_P2P with an entry queued
        bus1.cam_valid = 1'b1; bus1.cam_addr = 19'h60; bus1.cam_data = 12'hE60;
        frame_start = 1'b1;
        tick();
        chk("t6_in_drain", switching, 1);
        frame_start = 1'b0;
        bus1.cam_addr = 19'h61; bus1.cam_data = 12'hE61;
        tick();
        chk("t6_pre_rst_addr", bus1.mem_addr, 32'h60);
        rst_n = 1'b0; bus1.cam_valid = 1'b0;
        #1;
        chk("t6_rst_wen",   bus1.mem_wen,   0);
        chk("t6_rst_addr",  bus1.mem_addr,  0);
        chk("t6_rst_wdata", bus1.mem_wdata, 0);
        chk("t6_rst_cam_r", bus1.cam_ready, 0);
        chk("t6_rst_alu_r", bus1.alu_ready, 0);
        chk("t6_rst_ma",    mode_active,    0);
        chk("t6_rst_sw",    switching,      0);
        chk("t6_rst_ovf",   overflow_err,   0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_ready_back", bus1.cam_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_fifo_empty", bus1.mem_wen, 0);
            chk("t6_pass_sw",    switching,    0);
            chk("t6_pass_ma",    mode_active,  0);
        end
        mode_req = 1'b0;

        // 5: watermark above depth, ALU holds the port, fifth push is dropped
        mode_req2 = 1'b1; frame_start2 = 1'b1;
        tick();
        chk("t5_sw", sw2, 1);
        frame_start2 = 1'b0;
        tick();
        chk("t5_proc", ma2, 1);
        chk("t5_sw_off", sw2, 0);
        bus2.alu_valid = 1'b1; bus2.alu_addr = 19'h200; bus2.alu_data = 12'h3C3;
        bus2.cam_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus2.cam_addr = 19'h80 + 19'(j);
            bus2.cam_data = 12'hD00 + 12'(j);
            tick();
            chk("t5_alu_write", bus2.mem_addr,  32'h200);
            chk("t5_alu_wen",   bus2.mem_wen,   1);
            chk("t5_cam_ready", bus2.cam_ready, (j < 3));
            chk("t5_ovf",       ovf2,           (j == 4));
        end
        bus2.cam_valid = 1'b0; bus2.alu_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t5_drain_wen",  bus2.mem_wen,   1);
            chk("t5_drain_addr", bus2.mem_addr,  32'h80 + j);
            chk("t5_drain_data", bus2.mem_wdata, 32'hD00 + j);
        end
        tick();
        chk("t5_no_fifth",   bus2.mem_wen,   0);
        chk("t5_ovf_sticky", ovf2,           1);
        chk("t5_ready_back", bus2.cam_ready, 1);
        repeat (3) tick();
        chk("t5_ovf_still", ovf2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
